bus_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single bus controller among NUM_REQ requesters.
- Selects one requester, issues a one-cycle select/write command to the bus controller, then holds the grant until the controller returns i_ok. It then pulses a per-requester done and re-arbitrates.
- Sits between requester blocks and the bus controller FSM: drives its sel/write inputs and consumes its ok output.

---
 rtl/bus_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : bus_rr_arbiter                                             |
// | Description : Round-robin arbiter that shares one bus controller among   |
// |               NUM_REQ requesters. It issues a one-cycle sel strobe, holds |
// |               the grant until i_ok, then pulses a per-requester done.     |
// |               Optional WAIT timeout is enabled by the BUS_ARB_TIMEOUT_EN  |
// |               macro; without it WAIT holds until i_ok and o_timeout is 0. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module bus_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [NUM_REQ-1:0] i_wr,
   input  logic               i_ok,
   output logic               o_sel,
   output logic               o_write,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [NUM_REQ-1:0] o_done,
   output logic               o_busy,
   output logic               o_timeout
);

   localparam int                 IW        = $clog2(NUM_REQ);
   localparam logic [IW-1:0]      c_PTR_RST = IW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] c_ONE     = NUM_REQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IW-1:0]        r_ptr;
   logic [IW-1:0]        r_idx;
   logic                 r_dir;
   logic [IW-1:0]        w_win_idx;
   logic                 w_win_vld;
   logic                 w_to_hit;
   logic [NUM_REQ-1:0]   w_idx_oh;

   // Reject out-of-range configurations at elaboration time
   generate
      if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
         $error("bus_rr_arbiter: NUM_REQ must be in 2..16");
      end
      if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
         $error("bus_rr_arbiter: TIMEOUT must be in 1..255");
      end
   endgenerate

   assign w_idx_oh = c_ONE << r_idx;

   // Round-robin search: first requester after r_ptr, wrapping at NUM_REQ
   always_comb begin
      int cand;
      cand      = 0;
      w_win_vld = 1'b0;
      w_win_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(r_ptr) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!w_win_vld && i_req[IW'(cand)]) begin
            w_win_vld = 1'b1;
            w_win_idx = IW'(cand);
         end
      end
   end

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int            CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] c_TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] c_TO_MAX  = CW'(TIMEOUT);

   logic [CW-1:0] r_to_cnt;
   logic          r_to_flag;

   // Abort WAIT on the last allowed cycle unless the controller answers now
   assign w_to_hit = (r_state == ST_WAIT) && !i_ok && (r_to_cnt == c_TO_LAST);

   // WAIT cycle counter (saturating) and the abort flag shown during DONE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_to_cnt  <= '0;
         r_to_flag <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT: begin
               if (!i_ok && (r_to_cnt != c_TO_MAX)) begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
               r_to_flag <= w_to_hit;
            end
            ST_DONE: begin
               r_to_cnt  <= '0;
               r_to_flag <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_timeout = (r_state == ST_DONE) && r_to_flag;
`else
   assign w_to_hit  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and outputs decoded from registered state only
   always_comb begin
      w_state_nxt = r_state;
      o_sel       = 1'b0;
      o_write     = 1'b0;
      o_gnt       = '0;
      o_done      = '0;
      o_busy      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_win_vld) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            o_sel       = 1'b1;
            o_write     = r_dir;
            o_gnt       = w_idx_oh;
            o_busy      = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            o_write = r_dir;
            o_gnt   = w_idx_oh;
            o_busy  = 1'b1;
            if (i_ok || w_to_hit) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_write     = r_dir;
            o_gnt       = w_idx_oh;
            o_done      = w_idx_oh;
            o_busy      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Latch winner and direction at grant; advance pointer on completion
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr <= c_PTR_RST;
         r_idx <= '0;
         r_dir <= 1'b0;
      end else if ((r_state == ST_IDLE) && w_win_vld) begin
         r_idx <= w_win_idx;
         r_dir <= i_wr[w_win_idx];
      end else if (r_state == ST_DONE) begin
         r_ptr <= r_idx;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbiter.sv
`default_nettype none
// Testbench for bus_rr_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_bus_rr_arbiter;

   localparam int N    = 4;
   localparam int TO   = 8;
   localparam int MAXC = 200;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] i_req = '0;
   logic [N-1:0] i_wr  = '0;
   logic         i_ok  = 1'b0;
   logic         o_sel, o_write, o_busy, o_timeout;
   logic [N-1:0] o_gnt, o_done;

   int checks = 0;
   int errors = 0;
   int m_ptr  = N - 1;

   typedef struct {
      int           lat;
      logic [N-1:0] sel_gnt;
      logic         sel_write;
      logic         stable;
      int           nwait;
      logic [N-1:0] done_vec;
      logic [N-1:0] done_gnt;
      logic         done_write;
      logic         done_to;
      logic         to_any;
      logic         idle_ok;
   } obs_t;

   always #5 clk = ~clk;

   bus_rr_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_req     (i_req),
      .i_wr      (i_wr),
      .i_ok      (i_ok),
      .o_sel     (o_sel),
      .o_write   (o_write),
      .o_gnt     (o_gnt),
      .o_done    (o_done),
      .o_busy    (o_busy),
      .o_timeout (o_timeout)
   );

   // ---------------- reference model ----------------
   function automatic int model_winner(input logic [N-1:0] req, input int ptr);
      int w;
      for (int k = 1; k <= N; k++) begin
         w = (ptr + k) % N;
         if (req[w]) return w;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   // WAIT cycles expected when i_ok rises after okdly quiet WAIT cycles (<0: never)
   function automatic int model_nwait(input int okdly);
`ifdef BUS_ARB_TIMEOUT_EN
      if (okdly < 0 || okdly + 1 > TO) return TO;
`endif
      return okdly + 1;
   endfunction

   function automatic logic model_to(input int okdly);
`ifdef BUS_ARB_TIMEOUT_EN
      return (okdly < 0 || okdly + 1 > TO);
`else
      return (okdly < 0) ? 1'b0 : 1'b0;
`endif
   endfunction

   function automatic logic outs_zero();
      return (o_sel === 1'b0) && (o_write === 1'b0) && (o_gnt === '0) &&
             (o_done === '0) && (o_busy === 1'b0) && (o_timeout === 1'b0);
   endfunction

   // Drive one transaction starting from an IDLE negedge; returns observations
   task automatic do_txn(input logic [N-1:0] req, input logic [N-1:0] wr,
                         input logic [N-1:0] req_after, input logic [N-1:0] wr_after,
                         input int okdly, input logic ok_early, output obs_t o);
      o.lat = 0; o.sel_gnt = '0; o.sel_write = 1'b0; o.stable = 1'b0; o.nwait = 0;
      o.done_vec = '0; o.done_gnt = '0; o.done_write = 1'b0; o.done_to = 1'b0;
      o.to_any = 1'b0; o.idle_ok = 1'b0;
      i_req = req; i_wr = wr; i_ok = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (o_sel === 1'b1) begin o.lat = c; break; end
      end
      if (o.lat == 0) return;
      o.sel_gnt = o_gnt; o.sel_write = o_write; o.stable = o_busy;
      i_ok = ok_early;
      for (int c = 0; c < MAXC; c++) begin
         @(negedge clk);
         if (o_timeout === 1'b1) o.to_any = 1'b1;
         if (o_done !== '0) begin
            o.done_vec = o_done; o.done_gnt = o_gnt; o.done_write = o_write; o.done_to = o_timeout;
            break;
         end
         if (o_sel !== 1'b0 || o_gnt !== o.sel_gnt || o_write !== o.sel_write || o_busy !== 1'b1)
            o.stable = 1'b0;
         o.nwait++;
         if (o.nwait == 1) begin i_req = req_after; i_wr = wr_after; end
         i_ok = (okdly >= 0 && o.nwait > okdly);
      end
      i_ok = 1'b0;
      @(negedge clk);
      o.idle_ok = outs_zero();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int bad;
      rst_n = 1'b0; i_req = '0; i_wr = '0; i_ok = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (!outs_zero()) begin errors++; $display("FAIL reset_outs: got sel=%b gnt=%b busy=%b expected all 0", o_sel, o_gnt, o_busy); end
      rst_n = 1'b1;
      m_ptr = N - 1;
      bad = 0;
      for (int c = 0; c < 10; c++) begin @(negedge clk); if (!outs_zero()) bad++; end
      checks++; if (bad !== 0) begin errors++; $display("FAIL idle_outs: got %0d non-zero cycles expected 0", bad); end
   endtask

   task automatic test_first_request();
      obs_t o;
      do_txn(4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 1'b0, o);
      checks++; if (o.lat !== 1) begin errors++; $display("FAIL first_lat: got %0d expected 1", o.lat); end
      checks++; if (o.sel_gnt !== 4'b0001) begin errors++; $display("FAIL first_gnt: got %b expected 0001", o.sel_gnt); end
      checks++; if (o.done_vec !== 4'b0001) begin errors++; $display("FAIL first_done: got %b expected 0001", o.done_vec); end
      checks++; if (o.nwait !== 2) begin errors++; $display("FAIL first_nwait: got %0d expected 2", o.nwait); end
      m_ptr = 0;
   endtask

   task automatic test_round_robin();
      obs_t o;
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] wr = 4'b1010;
      rst_n = 1'b0; i_req = '0;
      @(negedge clk);
      rst_n = 1'b1; m_ptr = N - 1;
      for (int t = 0; t < 5; t++) begin
         do_txn(4'b1111, wr, 4'b1111, wr, 1, 1'b0, o);
         checks++; if (o.lat !== 1) begin errors++; $display("FAIL rr_lat[%0d]: got %0d expected 1", t, o.lat); end
         checks++; if (o.sel_gnt !== onehot(exp_order[t])) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", t, o.sel_gnt, onehot(exp_order[t])); end
         checks++; if (o.sel_write !== wr[exp_order[t]]) begin errors++; $display("FAIL rr_write[%0d]: got %b expected %b", t, o.sel_write, wr[exp_order[t]]); end
         checks++; if (o.done_vec !== onehot(exp_order[t]) || o.done_gnt !== onehot(exp_order[t])) begin errors++; $display("FAIL rr_done[%0d]: got %b/%b expected %b", t, o.done_vec, o.done_gnt, onehot(exp_order[t])); end
         checks++; if (o.idle_ok !== 1'b1) begin errors++; $display("FAIL rr_idle[%0d]: got %b expected 1", t, o.idle_ok); end
         m_ptr = exp_order[t];
      end
   endtask

   task automatic test_grant_lock();
      obs_t o;
      int sels;
      do_txn(4'b0100, 4'b0100, 4'b0000, 4'b0000, 3, 1'b0, o);
      checks++; if (o.sel_gnt !== 4'b0100 || o.sel_write !== 1'b1) begin errors++; $display("FAIL lock_gnt: got %b/%b expected 0100/1", o.sel_gnt, o.sel_write); end
      checks++; if (o.stable !== 1'b1 || o.done_write !== 1'b1) begin errors++; $display("FAIL lock_hold: got stable=%b write=%b expected 1/1", o.stable, o.done_write); end
      checks++; if (o.done_vec !== 4'b0100) begin errors++; $display("FAIL lock_done: got %b expected 0100", o.done_vec); end
      m_ptr = 2;
      sels = 0;
      for (int c = 0; c < 4; c++) begin @(negedge clk); if (o_sel !== 1'b0 || o_busy !== 1'b0) sels++; end
      checks++; if (sels !== 0) begin errors++; $display("FAIL lock_no_sel: got %0d busy cycles expected 0", sels); end
   endtask

   task automatic test_reset_mid_wait();
      obs_t o;
      i_req = 4'b0010; i_wr = 4'b0000;
      @(negedge clk);
      checks++; if (o_sel !== 1'b1 || o_gnt !== 4'b0010) begin errors++; $display("FAIL mid_sel: got %b/%b expected 1/0010", o_sel, o_gnt); end
      @(negedge clk);
      checks++; if (o_sel !== 1'b0 || o_gnt !== 4'b0010) begin errors++; $display("FAIL mid_wait: got %b/%b expected 0/0010", o_sel, o_gnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (!outs_zero()) begin errors++; $display("FAIL mid_async: got gnt=%b busy=%b expected 0/0", o_gnt, o_busy); end
      i_req = '0;
      @(negedge clk);
      rst_n = 1'b1; m_ptr = N - 1;
      do_txn(4'b0011, 4'b0001, 4'b0011, 4'b0001, 0, 1'b1, o);
      checks++; if (o.sel_gnt !== 4'b0001 || o.sel_write !== 1'b1) begin errors++; $display("FAIL mid_regrant: got %b/%b expected 0001/1", o.sel_gnt, o.sel_write); end
      m_ptr = 0;
   endtask

   task automatic test_single();
      obs_t o;
      for (int t = 0; t < 3; t++) begin
         do_txn(4'b1000, 4'b0000, 4'b1000, 4'b0000, t, 1'b0, o);
         checks++; if (o.sel_gnt !== 4'b1000 || o.done_vec !== 4'b1000) begin errors++; $display("FAIL single[%0d]: got %b/%b expected 1000", t, o.sel_gnt, o.done_vec); end
         m_ptr = 3;
      end
   endtask

   task automatic test_fairness();
      obs_t o;
      int gap, max_gap;
      gap = 0; max_gap = 0;
      for (int t = 0; t < 16; t++) begin
         do_txn(4'($urandom_range(0, 15)) | 4'b0100, 4'($urandom_range(0, 15)), 4'b0100, 4'b0000, 0, 1'b0, o);
         gap++;
         if (o.sel_gnt === 4'b0100) begin if (gap > max_gap) max_gap = gap; gap = 0; end
         for (int k = 0; k < N; k++) if (o.sel_gnt[k] === 1'b1) m_ptr = k;
      end
      if (gap > max_gap) max_gap = gap;
      checks++; if (max_gap > N) begin errors++; $display("FAIL fairness: got gap %0d expected <= %0d", max_gap, N); end
   endtask

   task automatic test_random();
      obs_t o;
      logic [N-1:0] req, wr;
      int exp, okdly, bad;
      for (int t = 0; t < 40; t++) begin
         req   = 4'($urandom_range(1, 15));
         wr    = 4'($urandom_range(0, 15));
         okdly = $urandom_range(0, 5);
         exp   = model_winner(req, m_ptr);
         do_txn(req, wr, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), okdly, 1'($urandom_range(0, 1)), o);
         checks++; if (o.lat !== 1) begin errors++; $display("FAIL rand_lat[%0d]: got %0d expected 1", t, o.lat); end
         checks++; if (o.sel_gnt !== onehot(exp) || o.sel_write !== wr[exp]) begin errors++; $display("FAIL rand_gnt[%0d]: got %b/%b expected %b/%b", t, o.sel_gnt, o.sel_write, onehot(exp), wr[exp]); end
         checks++; if (o.stable !== 1'b1 || o.done_gnt !== onehot(exp) || o.done_write !== wr[exp]) begin errors++; $display("FAIL rand_hold[%0d]: got stable=%b gnt=%b expected 1/%b", t, o.stable, o.done_gnt, onehot(exp)); end
         checks++; if (o.nwait !== model_nwait(okdly)) begin errors++; $display("FAIL rand_nwait[%0d]: got %0d expected %0d", t, o.nwait, model_nwait(okdly)); end
         checks++; if (o.done_vec !== onehot(exp) || o.done_to !== 1'b0 || o.idle_ok !== 1'b1) begin errors++; $display("FAIL rand_done[%0d]: got %b to=%b idle=%b expected %b/0/1", t, o.done_vec, o.done_to, o.idle_ok, onehot(exp)); end
         m_ptr = exp;
         if ($urandom_range(0, 3) == 0) begin
            i_req = '0; bad = 0;
            repeat ($urandom_range(1, 3)) begin @(negedge clk); if (!outs_zero()) bad++; end
            checks++; if (bad !== 0) begin errors++; $display("FAIL rand_gap[%0d]: got %0d busy cycles expected 0", t, bad); end
         end
      end
   endtask

   task automatic test_long_wait();
      obs_t o;
      int exp, okdly;
`ifdef BUS_ARB_TIMEOUT_EN
      okdly = -1;
`else
      okdly = 100;
`endif
      exp = model_winner(4'b0110, m_ptr);
      do_txn(4'b0110, 4'b0010, 4'b0000, 4'b0000, okdly, 1'b0, o);
      checks++; if (o.nwait !== model_nwait(okdly)) begin errors++; $display("FAIL long_nwait: got %0d expected %0d", o.nwait, model_nwait(okdly)); end
      checks++; if (o.stable !== 1'b1 || o.sel_gnt !== onehot(exp)) begin errors++; $display("FAIL long_hold: got stable=%b gnt=%b expected 1/%b", o.stable, o.sel_gnt, onehot(exp)); end
      checks++; if (o.done_vec !== onehot(exp) || o.done_to !== model_to(okdly) || o.to_any !== model_to(okdly)) begin errors++; $display("FAIL long_done: got %b to=%b expected %b to=%b", o.done_vec, o.done_to, onehot(exp), model_to(okdly)); end
      m_ptr = exp;
`ifdef BUS_ARB_TIMEOUT_EN
      exp = model_winner(4'b0110, m_ptr);
      do_txn(4'b0110, 4'b0010, 4'b0000, 4'b0000, TO - 1, 1'b0, o);
      checks++; if (o.nwait !== TO || o.done_to !== 1'b0 || o.done_vec !== onehot(exp)) begin errors++; $display("FAIL to_edge: got nwait=%0d to=%b done=%b expected %0d/0/%b", o.nwait, o.done_to, o.done_vec, TO, onehot(exp)); end
      m_ptr = exp;
`endif
   endtask

   initial begin
      test_reset();
      test_first_request();
      test_round_robin();
      test_grant_lock();
      test_reset_mid_wait();
      test_single();
      test_fairness();
      test_random();
      test_long_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
